// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, register-zero
// constant, default stall-sequencing parameters and counter widths.
// Imported by the hazard controller and its load-use compare.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_LOAD_BUBBLES = 1;
    localparam int DEF_MAX_WAIT     = 255;

    localparam int BUB_W  = 3;
    localparam int WAIT_W = 8;

endpackage : pipeline_ctrl_pkg

// File: rtl/load_use_detector.sv
// Purpose: flags a load in EX whose destination feeds the instruction in ID.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result is consumed by the hazard FSM.
//
// Ports:
//   id_rs_i, id_rt_i     source fields of the ID instruction
//   id_uses_rt_i         ID instruction actually reads rt
//   ex_mem_read_i        EX instruction is a load
//   ex_write_reg_i       destination register of the EX instruction
//   load_use_o           stall required
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_write_reg_i,
    output logic       load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_write_reg_i == id_rs_i);
    // An rt match only matters when the ID instruction really reads rt
    // (stores and R-types do, I-type ALU ops do not).
    assign rt_hit = id_uses_rt_i & (ex_write_reg_i == id_rt_i);

    // $0 is hard-wired, so a load into it can never create a dependency.
    assign load_use_o = ex_mem_read_i & (ex_write_reg_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule : load_use_detector

// File: rtl/hazard_stall_controller.sv
// Purpose: central hazard sequencer (load-use bubbles, branch/jump flush, data-memory wait).
// Latency: control outputs are Mealy (same cycle); state updates on the falling clk edge.
// Backpressure: MemBusy freezes EX/MEM onward and stalls PC/IF/ID until ready or MAX_WAIT timeout.
//
// Ports:
//   clk, reset (async, active-low)
//   in_ID_rs/rt/UsesRt/Jump       ID-stage fields
//   in_EX_MemRead/WriteRegister   EX-stage load information
//   in_EX_BranchTaken             branch resolved taken in EX
//   in_MemBusy                    data memory not ready
//   out_PCWrite, out_IFID_Write   front-end load enables
//   out_IFID_Flush, out_IDEX_Flush, out_EXMEM_Hold   pipeline register controls
//   out_MemTimeout                sticky memory timeout flag
//   out_StallCycles               saturating count of PCWrite=0 cycles
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int NBits        = 32,
    parameter int LOAD_BUBBLES = DEF_LOAD_BUBBLES,
    parameter int MAX_WAIT     = DEF_MAX_WAIT,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       in_ID_rs,
    input  logic [4:0]       in_ID_rt,
    input  logic             in_ID_UsesRt,
    input  logic             in_ID_Jump,
    input  logic             in_EX_MemRead,
    input  logic [4:0]       in_EX_WriteRegister,
    input  logic             in_EX_BranchTaken,
    input  logic             in_MemBusy,
    output logic             out_PCWrite,
    output logic             out_IFID_Write,
    output logic             out_IFID_Flush,
    output logic             out_IDEX_Flush,
    output logic             out_EXMEM_Hold,
    output logic             out_MemTimeout,
    output logic [CNT_W-1:0] out_StallCycles
);

    localparam logic [BUB_W-1:0]  LB_FIRST_RELOAD = BUB_W'(LOAD_BUBBLES - 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C      = WAIT_W'(MAX_WAIT);

    // NBits only keeps the instance shape uniform with the datapath blocks.
    logic nbits_unused;
    assign nbits_unused = (NBits > 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [BUB_W-1:0]    bub_q, bub_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [BUB_W-1:0]    ret_q, ret_d;
    logic                timeout_q;
    logic                ignore_busy_q, ignore_busy_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic                load_use;
    logic                busy;
    logic                timeout_set;
    logic                enter_wait;
    state_e              eff_state;
    logic [BUB_W-1:0]    eff_bub;
    logic [WAIT_W-1:0]   wait_inc;

    logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold;

    load_use_detector u_load_use (
        .id_rs_i        (in_ID_rs),
        .id_rt_i        (in_ID_rt),
        .id_uses_rt_i   (in_ID_UsesRt),
        .ex_mem_read_i  (in_EX_MemRead),
        .ex_write_reg_i (in_EX_WriteRegister),
        .load_use_o     (load_use)
    );

    // After a timeout the stuck MemBusy is masked for one cycle so the
    // pipeline can make forward progress instead of re-entering the wait.
    assign busy     = in_MemBusy & ~ignore_busy_q;
    assign wait_inc = wait_q + WAIT_W'(1);

    // ------------------------------------------------------------------
    // Next-state and Mealy output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bub_d         = bub_q;
        wait_d        = '0;
        ret_d         = ret_q;
        ignore_busy_d = 1'b0;
        timeout_set   = 1'b0;
        enter_wait    = 1'b0;

        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;

        // The cycle MemBusy drops, EX/MEM is free to advance, so that cycle
        // already behaves like the state being resumed: either the first of
        // the remaining load bubbles or a normal RUN cycle.
        eff_state = state_q;
        eff_bub   = bub_q;
        if ((state_q == MEM_WAIT) && !busy) begin
            eff_state = (ret_q != '0) ? LOAD_STALL : RUN;
            eff_bub   = ret_q;
            ret_d     = '0;
            state_d   = eff_state;
        end

        case (eff_state)
            RUN: begin
                if (busy) begin
                    enter_wait = 1'b1;
                    ret_d      = '0;
                end else if (in_EX_BranchTaken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (in_ID_Jump) begin
                    ifid_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        bub_d   = LB_FIRST_RELOAD;
                        state_d = LOAD_STALL;
                    end
                end
            end

            LOAD_STALL: begin
                if (busy) begin
                    // Park the remaining bubble count until memory returns.
                    enter_wait = 1'b1;
                    ret_d      = eff_bub;
                end else if (in_EX_BranchTaken) begin
                    // The stalled ID instruction is on the wrong path anyway.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    bub_d      = '0;
                    state_d    = RUN;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    bub_d      = (eff_bub != '0) ? eff_bub - BUB_W'(1) : '0;
                    state_d    = (eff_bub <= BUB_W'(1)) ? RUN : LOAD_STALL;
                end
            end

            MEM_WAIT: begin
                // Only reached with MemBusy high; EX is frozen so a branch
                // indication here is stale and ignored.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                exmem_hold = 1'b1;
                if (wait_inc >= MAX_WAIT_C) begin
                    timeout_set   = 1'b1;
                    ignore_busy_d = 1'b1;
                    ret_d         = '0;
                    state_d       = RUN;
                end else begin
                    wait_d = wait_inc;
                end
            end

            default: begin
                state_d = RUN;
                bub_d   = '0;
                ret_d   = '0;
            end
        endcase

        // Common entry into the memory wait: this cycle is wait cycle 1.
        if (enter_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b0;
            exmem_hold = 1'b1;
            if (MAX_WAIT_C <= WAIT_W'(1)) begin
                timeout_set   = 1'b1;
                ignore_busy_d = 1'b1;
                ret_d         = '0;
                state_d       = RUN;
            end else begin
                wait_d  = WAIT_W'(1);
                state_d = MEM_WAIT;
            end
        end

        stall_d = stall_q;
        if (!pc_write && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers: falling edge, in step with the pipeline registers
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            bub_q         <= '0;
            wait_q        <= '0;
            ret_q         <= '0;
            timeout_q     <= 1'b0;
            ignore_busy_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            bub_q         <= bub_d;
            wait_q        <= wait_d;
            ret_q         <= ret_d;
            timeout_q     <= timeout_q | timeout_set;
            ignore_busy_q <= ignore_busy_d;
            stall_q       <= stall_d;
        end
    end

    // While reset is low every pipeline control is held inactive.
    assign out_PCWrite     = reset & pc_write;
    assign out_IFID_Write  = reset & ifid_write;
    assign out_IFID_Flush  = reset & ifid_flush;
    assign out_IDEX_Flush  = reset & idex_flush;
    assign out_EXMEM_Hold  = reset & exmem_hold;
    assign out_MemTimeout  = timeout_q;
    assign out_StallCycles = stall_q;

endmodule : hazard_stall_controller

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Two instances share stimulus:
// dut1 (LOAD_BUBBLES=1, MAX_WAIT=4) and dut3 (LOAD_BUBBLES=3, MAX_WAIT=255).
// Control outputs are compared as {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold}.
module tb_hazard_stall_controller;

    localparam logic [4:0] C_OFF  = 5'b00000;
    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_BUB  = 5'b00010;
    localparam logic [4:0] C_HOLD = 5'b00001;
    localparam logic [4:0] C_BR   = 5'b11110;
    localparam logic [4:0] C_JMP  = 5'b11100;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wr;
    logic       id_uses_rt, id_jump, ex_mem_read, ex_br, mem_busy;

    logic        pcw1, ifw1, iff1, idf1, hold1, to1;
    logic        pcw3, ifw3, iff3, idf3, hold3, to3;
    logic [15:0] sc1, sc3;
    logic [4:0]  ctl1, ctl3;

    int checks = 0;
    int errors = 0;

    assign ctl1 = {pcw1, ifw1, iff1, idf1, hold1};
    assign ctl3 = {pcw3, ifw3, iff3, idf3, hold3};

    hazard_stall_controller #(.NBits(32), .LOAD_BUBBLES(1), .MAX_WAIT(4), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset),
        .in_ID_rs(id_rs), .in_ID_rt(id_rt), .in_ID_UsesRt(id_uses_rt), .in_ID_Jump(id_jump),
        .in_EX_MemRead(ex_mem_read), .in_EX_WriteRegister(ex_wr),
        .in_EX_BranchTaken(ex_br), .in_MemBusy(mem_busy),
        .out_PCWrite(pcw1), .out_IFID_Write(ifw1), .out_IFID_Flush(iff1),
        .out_IDEX_Flush(idf1), .out_EXMEM_Hold(hold1),
        .out_MemTimeout(to1), .out_StallCycles(sc1)
    );

    hazard_stall_controller #(.NBits(32), .LOAD_BUBBLES(3), .MAX_WAIT(255), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset),
        .in_ID_rs(id_rs), .in_ID_rt(id_rt), .in_ID_UsesRt(id_uses_rt), .in_ID_Jump(id_jump),
        .in_EX_MemRead(ex_mem_read), .in_EX_WriteRegister(ex_wr),
        .in_EX_BranchTaken(ex_br), .in_MemBusy(mem_busy),
        .out_PCWrite(pcw3), .out_IFID_Write(ifw3), .out_IFID_Flush(iff3),
        .out_IDEX_Flush(idf3), .out_EXMEM_Hold(hold3),
        .out_MemTimeout(to3), .out_StallCycles(sc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_wr = 5'd0; ex_br = 1'b0; mem_busy = 1'b0;
    endtask

    // lw $8 in EX, add $9,$8,$1 in ID
    task automatic drive_hazard();
        ex_mem_read = 1'b1; ex_wr = 5'd8; id_rs = 5'd8; id_rt = 5'd1; id_uses_rt = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        drive_hazard();
        reset = 1'b0;
        #2;
        checks++; if (ctl1 !== C_OFF) begin errors++; $display("FAIL reset_ctl1: got %b expected %b", ctl1, C_OFF); end
        checks++; if (ctl3 !== C_OFF) begin errors++; $display("FAIL reset_ctl3: got %b expected %b", ctl3, C_OFF); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", to1); end
        checks++; if (sc3 !== 16'd0) begin errors++; $display("FAIL reset_stallcnt: got %0d expected 0", sc3); end
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL reset_release: got %b expected %b", ctl1, C_RUN); end
        next_cycle();
    endtask

    task automatic test_load_use_1();
        apply_reset();
        drive_hazard();
        #1;
        checks++; if (ctl1 !== C_BUB) begin errors++; $display("FAIL lu1_bubble: got %b expected %b", ctl1, C_BUB); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL lu1_resume: got %b expected %b", ctl1, C_RUN); end
        checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL lu1_stallcnt: got %0d expected 1", sc1); end
    endtask

    task automatic test_load_use_3();
        logic [4:0] exp;
        apply_reset();
        drive_hazard();
        for (int i = 0; i < 4; i++) begin
            exp = (i < 3) ? C_BUB : C_RUN;
            #1;
            checks++; if (ctl3 !== exp) begin errors++; $display("FAIL lu3_cycle%0d: got %b expected %b", i, ctl3, exp); end
            next_cycle();
            if (i == 0) idle_inputs();
        end
        checks++; if (sc3 !== 16'd3) begin errors++; $display("FAIL lu3_stallcnt: got %0d expected 3", sc3); end
    endtask

    task automatic test_no_hazard();
        apply_reset();
        ex_mem_read = 1'b1; ex_wr = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL nh_reg0: got %b expected %b", ctl1, C_RUN); end
        ex_wr = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL nh_rt_unused: got %b expected %b", ctl3, C_RUN); end
        id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl3 !== C_BUB) begin errors++; $display("FAIL nh_rt_used: got %b expected %b", ctl3, C_BUB); end
        ex_mem_read = 1'b0;
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL nh_not_load: got %b expected %b", ctl1, C_RUN); end
        next_cycle();
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL nh_stallcnt: got %0d expected 0", sc1); end
    endtask

    task automatic test_branch_jump();
        apply_reset();
        drive_hazard();
        ex_br = 1'b1;
        #1;
        checks++; if (ctl1 !== C_BR) begin errors++; $display("FAIL br_over_lu1: got %b expected %b", ctl1, C_BR); end
        checks++; if (ctl3 !== C_BR) begin errors++; $display("FAIL br_over_lu3: got %b expected %b", ctl3, C_BR); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL br_stays_run: got %b expected %b", ctl3, C_RUN); end
        checks++; if (sc3 !== 16'd0) begin errors++; $display("FAIL br_stallcnt: got %0d expected 0", sc3); end
        id_jump = 1'b1;
        #1;
        checks++; if (ctl1 !== C_JMP) begin errors++; $display("FAIL jump_only: got %b expected %b", ctl1, C_JMP); end
        drive_hazard();
        #1;
        checks++; if (ctl1 !== C_JMP) begin errors++; $display("FAIL jump_over_lu: got %b expected %b", ctl1, C_JMP); end
        next_cycle();
        // branch resolved while dut3 is inside its load bubbles
        idle_inputs();
        drive_hazard();
        next_cycle();
        idle_inputs();
        ex_br = 1'b1;
        #1;
        checks++; if (ctl3 !== C_BR) begin errors++; $display("FAIL br_in_stall: got %b expected %b", ctl3, C_BR); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL br_stall_exit: got %b expected %b", ctl3, C_RUN); end
    endtask

    task automatic test_busy_in_load_stall();
        apply_reset();
        drive_hazard();
        #1;
        checks++; if (ctl3 !== C_BUB) begin errors++; $display("FAIL bs_first_bubble: got %b expected %b", ctl3, C_BUB); end
        next_cycle();
        idle_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ctl3 !== C_HOLD) begin errors++; $display("FAIL bs_hold%0d: got %b expected %b", i, ctl3, C_HOLD); end
            next_cycle();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctl3 !== C_BUB) begin errors++; $display("FAIL bs_bubble%0d: got %b expected %b", i, ctl3, C_BUB); end
            next_cycle();
        end
        #1;
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL bs_resume: got %b expected %b", ctl3, C_RUN); end
        checks++; if (sc3 !== 16'd8) begin errors++; $display("FAIL bs_stallcnt: got %0d expected 8", sc3); end
        checks++; if (to3 !== 1'b0) begin errors++; $display("FAIL bs_no_timeout: got %b expected 0", to3); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ctl1 !== C_HOLD) begin errors++; $display("FAIL to_hold%0d: got %b expected %b", i, ctl1, C_HOLD); end
            checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b expected 0", i, to1); end
            next_cycle();
        end
        #1;
        checks++; if (to1 !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", to1); end
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL to_busy_ignored: got %b expected %b", ctl1, C_RUN); end
        checks++; if (sc1 !== 16'd4) begin errors++; $display("FAIL to_stallcnt: got %0d expected 4", sc1); end
        next_cycle();
        #1;
        checks++; if (ctl1 !== C_HOLD) begin errors++; $display("FAIL to_busy_again: got %b expected %b", ctl1, C_HOLD); end
        next_cycle();
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL to_release: got %b expected %b", ctl1, C_RUN); end
        next_cycle();
        #1;
        checks++; if (to1 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", to1); end
    endtask

    task automatic test_reset_mid_wait();
        // dut1 still carries the sticky timeout from the previous scenario
        idle_inputs();
        mem_busy = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (ctl3 !== C_HOLD) begin errors++; $display("FAIL rm_in_wait: got %b expected %b", ctl3, C_HOLD); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (ctl1 !== C_OFF) begin errors++; $display("FAIL rm_ctl1: got %b expected %b", ctl1, C_OFF); end
        checks++; if (ctl3 !== C_OFF) begin errors++; $display("FAIL rm_ctl3: got %b expected %b", ctl3, C_OFF); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL rm_timeout_clr: got %b expected 0", to1); end
        checks++; if (sc3 !== 16'd0) begin errors++; $display("FAIL rm_stallcnt: got %0d expected 0", sc3); end
        mem_busy = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL rm_release1: got %b expected %b", ctl1, C_RUN); end
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL rm_release3: got %b expected %b", ctl3, C_RUN); end
        next_cycle();
        #1;
        checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL rm_run_next: got %b expected %b", ctl3, C_RUN); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use_1();
        test_load_use_3();
        test_no_hazard();
        test_branch_jump();
        test_busy_in_load_stall();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hazard_stall_controller
